// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable integer clock divider with glitch-free ratio
// changes at period boundaries and clean start/stop sequencing.
module clk_div_ctrl #(
   parameter int DIV_W     = 8,
   parameter int RESET_DIV = 3
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             enable,
   input  logic [DIV_W-1:0] div_val,
   input  logic             div_load,
   output logic             div_ack,
   output logic             div_err,
   output logic             clock_out,
   output logic             clk_en,
   output logic             running,
   output logic [DIV_W-1:0] cur_div
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [DIV_W-1:0] cnt_reg, cnt_next;
   logic [DIV_W-1:0] cur_div_reg, cur_div_next;
   logic             pend_valid_reg, pend_valid_next;
   logic [DIV_W-1:0] pend_val_reg, pend_val_next;
   // Rejections that could not be reported because an ack owned that cycle.
   logic [1:0]       err_cnt_reg, err_cnt_next;

   logic             clock_out_reg, clock_out_next;
   logic             clk_en_reg, clk_en_next;
   logic             running_reg, running_next;
   logic             div_ack_reg, div_ack_next;
   logic             div_err_reg, div_err_next;

   logic             load_ok;
   logic             load_bad;
   logic             wrap;
   logic             apply;
   logic [2:0]       err_total;
   logic [DIV_W:0]   half_next;

   // Next-state, ratio application and registered-output precomputation.
   always_comb begin
      load_ok         = div_load && (div_val >= DIV_W'(2));
      load_bad        = div_load && (div_val <  DIV_W'(2));
      wrap            = (state_reg != ST_IDLE) && (cnt_reg == cur_div_reg - DIV_W'(1));

      // A load sampled this cycle joins (and overrides) the pending ratio.
      pend_valid_next = pend_valid_reg || load_ok;
      pend_val_next   = load_ok ? div_val : pend_val_reg;

      state_next      = state_reg;
      cnt_next        = cnt_reg;
      apply           = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            cnt_next = '0;
            apply    = pend_valid_next;
            if (enable) begin
               state_next = ST_RUN;
            end
         end
         default: begin
            // RUN and DRAIN count identically; they differ only at the wrap.
            if (wrap) begin
               cnt_next   = '0;
               apply      = pend_valid_next;
               state_next = enable ? ST_RUN : ST_IDLE;
            end else begin
               cnt_next   = cnt_reg + DIV_W'(1);
               state_next = enable ? ST_RUN : ST_DRAIN;
            end
         end
      endcase

      cur_div_next = cur_div_reg;
      if (apply) begin
         cur_div_next    = pend_val_next;
         pend_valid_next = 1'b0;
      end
      div_ack_next = apply;

      // div_err yields to div_ack; a displaced error is reported one cycle later.
      err_total = {1'b0, err_cnt_reg} + {2'b00, load_bad};
      if (err_total > 3'd3) begin
         err_total = 3'd3;
      end
      if (apply || err_total == 3'd0) begin
         div_err_next = 1'b0;
         err_cnt_next = err_total[1:0];
      end else begin
         div_err_next = 1'b1;
         err_cnt_next = err_total[1:0] - 2'd1;
      end

      half_next      = ({1'b0, cur_div_next} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
      running_next   = (state_next != ST_IDLE);
      clock_out_next = running_next && ({1'b0, cnt_next} < half_next);
      clk_en_next    = running_next && (cnt_next == cur_div_next - DIV_W'(1));
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= '0;
         cur_div_reg    <= DIV_W'(RESET_DIV);
         pend_valid_reg <= 1'b0;
         pend_val_reg   <= '0;
         err_cnt_reg    <= '0;
         clock_out_reg  <= 1'b0;
         clk_en_reg     <= 1'b0;
         running_reg    <= 1'b0;
         div_ack_reg    <= 1'b0;
         div_err_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         cur_div_reg    <= cur_div_next;
         pend_valid_reg <= pend_valid_next;
         pend_val_reg   <= pend_val_next;
         err_cnt_reg    <= err_cnt_next;
         clock_out_reg  <= clock_out_next;
         clk_en_reg     <= clk_en_next;
         running_reg    <= running_next;
         div_ack_reg    <= div_ack_next;
         div_err_reg    <= div_err_next;
      end
   end

   assign clock_out = clock_out_reg;
   assign clk_en    = clk_en_reg;
   assign running   = running_reg;
   assign div_ack   = div_ack_reg;
   assign div_err   = div_err_reg;
   assign cur_div   = cur_div_reg;

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Programmable integer clock-divider controller. It generates a registered divided clock (clock_out) and a one-cycle-per-period clock enable (clk_en) from clock_in. Software/control logic can change the divide ratio at any time; the change is applied only at a period boundary, so clock_out never glitches or produces a truncated period. It also sequences clean start/stop of the divided clock. The block sits between the control register interface and the fixed-ratio divider consumers.

Parameters:
DIV_W, 8, width of divide-ratio fields
RESET_DIV, 3, divide ratio after reset (must be >= 2 and < 2^DIV_W)

Ports:
clock_in  input  1  single system clock, rising edge only
reset  input  1  synchronous, active-high reset
enable  input  1  level; 1 = run divided clock, 0 = stop at next period boundary
div_val  input  DIV_W  requested divide ratio N
div_load  input  1  one-cycle strobe; div_val is sampled in this cycle
div_ack  output  1  one-cycle pulse; pending ratio applied
div_err  output  1  one-cycle pulse; rejected load (div_val < 2)
clock_out  output  1  divided clock, registered
clk_en  output  1  one-cycle pulse in the last cycle of each period
running  output  1  1 in RUN or DRAIN
cur_div  output  DIV_W  ratio of the period in progress

Behaviour:
- Reset, sampled at the rising edge: state=IDLE, cnt=0, cur_div=RESET_DIV, no pending ratio. clock_out, clk_en, running, div_ack and div_err are all 0. Reset overrides every other input, including mid-period and with a load pending; the pending ratio is discarded.
- States:
  - IDLE: clock_out=0; clk_en=0.
  - RUN: cnt counts 0..N-1 and wraps.
  - DRAIN: counts like RUN but stops at the next wrap.
- Duty cycle for N=cur_div: clock_out=1 while cnt < ceil(N/2), otherwise 0. For odd N, high for (N+1)/2 cycles and low for (N-1)/2. clk_en=1 when cnt==N-1 in RUN or DRAIN.
- Timing convention: all outputs are registered. "Cycle" means the state visible after a rising edge.
- IDLE->RUN: enable=1 sampled in IDLE. The next cycle has running=1, cnt=0, clock_out=1.
- RUN->DRAIN: enable=0 sampled in RUN with cnt != N-1. The period completes normally.
- RUN->IDLE: enable=0 sampled in RUN in the wrap cycle (cnt==N-1). Goes directly to IDLE.
- DRAIN->IDLE: after the wrap cycle.
- DRAIN->RUN: enable=1 sampled in DRAIN. No period disturbance.
- Wrap with enable=1: cnt returns to 0 and the next period starts with no idle gap.
- Ratio load:
  - div_load with div_val < 2: div_err=1 in the next cycle. Pending state and cur_div are unchanged.
  - div_load with div_val >= 2: the value becomes pending. A later load before application overwrites it (last wins); only one div_ack is produced.
- Application point:
  - In IDLE: a pending ratio is applied the next cycle.
  - In RUN/DRAIN: applied in the cycle after the wrap cycle, i.e. the first cycle of the new period.
  - div_ack=1 in the same cycle cur_div changes.
  - A valid load sampled in the wrap cycle itself is applied at that wrap.
- Load and enable rising in the same IDLE cycle: the first period already uses the new ratio, and div_ack fires in that first RUN cycle.
- Load in the final wrap (DRAIN or RUN->IDLE): the ratio is applied at that wrap. cur_div updates and div_ack fires in the first IDLE cycle.
- div_err and div_ack are never both 1 in the same cycle; a single load produces at most one of them.

Test Plan:
- Reset, then enable=1 held with RESET_DIV=3 -> clock_out 1,1,0 repeating; clk_en high on every third cycle, aligned with the low cycle; running=1 one cycle after enable.
- Load div_val=4 at cnt=0 of an N=3 period -> the N=3 period completes (1,1,0); div_ack and cur_div=4 on the next cycle; then clock_out 1,1,0,0 repeating.
- Load 5 then 6 on consecutive cycles mid-period -> exactly one div_ack; cur_div=6; no period of length 5 appears.
- Load div_val=1, then div_val=0 -> div_err pulses once each; cur_div and period unchanged; div_ack stays 0.
- Drop enable at cnt=0 with N=4 -> clock_out 1,1,0,0 with clk_en on the last cycle, then IDLE with clock_out=0 and running=0. Repeat with enable re-raised during DRAIN -> continuous periods, never idle.
- Assert reset mid-period with a load pending -> next cycle all outputs 0 and cur_div=3; the pending ratio is never applied and no div_ack occurs.
